// File: rtl/io_channels.sv
// Multi-channel CPU port I/O controller: per-channel TX/RX FIFOs,
// sticky error flags, interrupt enable and internal loopback.

module io_fifo #(
  parameter int width = 16,
  parameter int depth = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [width-1:0]         wdata,
  output logic [width-1:0]         rdata,
  output logic [$clog2(depth):0]   count
);
  localparam int aw = $clog2(depth);

  logic [width-1:0] mem [depth];
  logic [aw-1:0]    wr_ptr;
  logic [aw-1:0]    rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + aw'(1);
      if (pop)  rd_ptr <= rd_ptr + aw'(1);
      if (push && !pop)
        count <= count + (aw+1)'(1);
      else if (pop && !push)
        count <= count - (aw+1)'(1);
    end
  end

  assign rdata = mem[rd_ptr];
endmodule

module io_channels #(
  parameter int word_width = 16,
  parameter int port_width = 8,
  parameter int channels   = 4,
  parameter int fifo_depth = 8,
  parameter logic [port_width-1:0] base_port = 8'h00
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           io_oe,
  input  logic                           io_we,
  input  logic [port_width-1:0]          io_port,
  input  logic [word_width-1:0]          io_in,
  output logic [word_width-1:0]          io_out,
  output logic                           irq,
  output logic [channels-1:0]            tx_valid,
  input  logic [channels-1:0]            tx_ready,
  output logic [channels*word_width-1:0] tx_data,
  input  logic [channels-1:0]            rx_valid,
  output logic [channels-1:0]            rx_ready,
  input  logic [channels*word_width-1:0] rx_data
);
  localparam int aw = $clog2(fifo_depth);
  localparam int cw = aw + 1;
  localparam logic [cw-1:0] full_cnt = cw'(fifo_depth);

  // Extra top bit catches ports below base_port.
  logic [port_width:0]   off;
  logic [port_width-1:0] idx;
  logic                  hit;

  assign off = {1'b0, io_port} - {1'b0, base_port};
  assign idx = off[port_width:1];
  assign hit = !off[port_width]
            && (off < (port_width+1)'(2*channels));

  logic [channels-1:0]   rx_empty;
  logic [channels-1:0]   ie;
  logic [word_width-1:0] rx_head [channels];
  logic [word_width-1:0] stat    [channels];

  for (genvar i = 0; i < channels; i++) begin : g_ch
    logic            sel_d, sel_s;
    logic            wr_d, rd_d, wr_s;
    logic            tx_push, tx_pop;
    logic            rx_push, rx_pop;
    logic            tx_empty, tx_full, rx_full;
    logic            move;
    logic            ovf_q, unf_q, lb_q, ie_q;
    logic [cw-1:0]   tx_cnt, rx_cnt;
    logic [word_width-1:0] tx_head, rx_in;

    assign sel_d = hit && (idx == port_width'(i)) && !off[0];
    assign sel_s = hit && (idx == port_width'(i)) &&  off[0];
    assign wr_d  = io_we && sel_d;
    assign rd_d  = io_oe && !io_we && sel_d;
    assign wr_s  = io_we && sel_s;

    assign tx_empty    = (tx_cnt == '0);
    assign tx_full     = (tx_cnt == full_cnt);
    assign rx_empty[i] = (rx_cnt == '0);
    assign rx_full     = (rx_cnt == full_cnt);

    assign move    = lb_q && !tx_empty && !rx_full;
    assign tx_push = wr_d && !tx_full;
    assign tx_pop  = lb_q ? move : (!tx_empty && tx_ready[i]);
    assign rx_push = lb_q ? move : (rx_valid[i] && !rx_full);
    assign rx_pop  = rd_d && !rx_empty[i];
    assign rx_in   = lb_q ? tx_head
                          : rx_data[i*word_width +: word_width];

    assign tx_valid[i] = !lb_q && !tx_empty;
    assign rx_ready[i] = !lb_q && !rx_full;
    assign tx_data[i*word_width +: word_width] = tx_head;
    assign ie[i] = ie_q;

    io_fifo #(.width(word_width), .depth(fifo_depth)) u_tx (
      .clk   (clk),
      .rst   (rst),
      .push  (tx_push),
      .pop   (tx_pop),
      .wdata (io_in),
      .rdata (tx_head),
      .count (tx_cnt)
    );

    io_fifo #(.width(word_width), .depth(fifo_depth)) u_rx (
      .clk   (clk),
      .rst   (rst),
      .push  (rx_push),
      .pop   (rx_pop),
      .wdata (rx_in),
      .rdata (rx_head[i]),
      .count (rx_cnt)
    );

    // Error set wins over a coincident write-1-to-clear.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        ovf_q <= 1'b0;
        unf_q <= 1'b0;
        lb_q  <= 1'b0;
        ie_q  <= 1'b0;
      end else begin
        if (wr_d && tx_full)
          ovf_q <= 1'b1;
        else if (wr_s && io_in[4])
          ovf_q <= 1'b0;
        if (rd_d && rx_empty[i])
          unf_q <= 1'b1;
        else if (wr_s && io_in[5])
          unf_q <= 1'b0;
        if (wr_s) begin
          lb_q <= io_in[6];
          ie_q <= io_in[7];
        end
      end
    end

    always_comb begin
      stat[i] = '0;
      stat[i][7:0] = {ie_q, lb_q, unf_q, ovf_q,
                      tx_full, tx_empty, rx_full, rx_empty[i]};
      stat[i][8 +: cw] = rx_cnt;
    end
  end

  always_comb begin
    io_out = '0;
    if (rst && io_oe && !io_we && hit) begin
      for (int i = 0; i < channels; i++) begin
        if (idx == port_width'(i)) begin
          if (off[0])
            io_out = stat[i];
          else if (!rx_empty[i])
            io_out = rx_head[i];
        end
      end
    end
  end

  assign irq = |(ie & ~rx_empty);
endmodule

// File: tb/tb_io_channels.sv
// Scoreboard bench for io_channels: CPU reads and TX stream
// expectations queued by stimulus, checked by a negedge monitor.

module tb_io_channels;
  logic        clk = 1'b0;
  logic        rst;
  logic        io_oe, io_we;
  logic [7:0]  io_port;
  logic [15:0] io_in;
  logic [15:0] io_out;
  logic        irq;
  logic [3:0]  tx_valid, tx_ready;
  logic [63:0] tx_data;
  logic [3:0]  rx_valid, rx_ready;
  logic [63:0] rx_data;

  int tests = 0;
  int fails = 0;

  logic [15:0] rd_q  [$];
  string       tag_q [$];
  logic [19:0] tx_q  [$];

  io_channels #(
    .word_width (16),
    .port_width (8),
    .channels   (4),
    .fifo_depth (8),
    .base_port  (8'h00)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .io_oe    (io_oe),
    .io_we    (io_we),
    .io_port  (io_port),
    .io_in    (io_in),
    .io_out   (io_out),
    .irq      (irq),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_data  (tx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .rx_data  (rx_data)
  );

  always #5 clk = ~clk;

  // Monitor: consumes expectations whenever the DUT presents output.
  always @(negedge clk) begin
    logic [15:0] e;
    logic [19:0] te;
    string       t;
    if (io_oe) begin
      tests++;
      if (rd_q.size() == 0) begin
        fails++;
        $display("FAIL rd_unexpected: io_out=%h, no read queued", io_out);
      end else begin
        e = rd_q.pop_front();
        t = tag_q.pop_front();
        if (io_out !== e) begin
          fails++;
          $display("FAIL %s: io_out=%h expected %h", t, io_out, e);
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (tx_valid[i] && tx_ready[i]) begin
        tests++;
        if (tx_q.size() == 0) begin
          fails++;
          $display("FAIL tx_unexpected: ch%0d data=%h", i,
                   tx_data[i*16 +: 16]);
        end else begin
          te = tx_q.pop_front();
          if ({4'(i), tx_data[i*16 +: 16]} !== te) begin
            fails++;
            $display("FAIL tx_stream: got ch%0d %h expected ch%0d %h",
                     i, tx_data[i*16 +: 16], te[19:16], te[15:0]);
          end
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cpu_wr(input logic [7:0] p, input logic [15:0] d);
    io_we = 1'b1;
    io_port = p;
    io_in = d;
    cyc();
    io_we = 1'b0;
  endtask

  task automatic cpu_rd(input string name, input logic [7:0] p,
                        input logic [15:0] exp);
    rd_q.push_back(exp);
    tag_q.push_back(name);
    io_oe = 1'b1;
    io_port = p;
    cyc();
    io_oe = 1'b0;
  endtask

  task automatic dev_push(input int ch, input logic [15:0] d);
    rx_valid[ch] = 1'b1;
    rx_data[ch*16 +: 16] = d;
    cyc();
    rx_valid[ch] = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    io_oe = 1'b0;
    io_we = 1'b0;
    io_port = '0;
    io_in = '0;
    tx_ready = '0;
    rx_valid = '0;
    rx_data = '0;
    repeat (2) cyc();
    rst = 1'b1;
    cyc();

    // TX fill and overflow on ch0
    for (int k = 0; k < 9; k++) begin
      cpu_wr(8'h00, 16'h0100 + 16'(k));
      if (k < 8) tx_q.push_back({4'd0, 16'h0100 + 16'(k)});
    end
    cpu_rd("tx_full_ovf_status", 8'h01, 16'h0019);
    tx_ready[0] = 1'b1;
    repeat (10) cyc();
    tx_ready[0] = 1'b0;
    chk("tx_drained_no_0108", {31'b0, tx_valid[0]}, 32'd0);
    chk("tx_q_consumed", tx_q.size(), 32'd0);
    cpu_wr(8'h01, 16'h0010);
    cpu_rd("ovf_cleared", 8'h01, 16'h0005);

    // RX and underflow on ch2
    cpu_wr(8'h05, 16'h0080);
    dev_push(2, 16'hBEEF);
    dev_push(2, 16'hCAFE);
    chk("irq_rx_pending", {31'b0, irq}, 32'd1);
    cpu_rd("rx_status_cnt2", 8'h05, 16'h0284);
    cpu_rd("rx_beef", 8'h04, 16'hBEEF);
    cpu_rd("rx_cafe", 8'h04, 16'hCAFE);
    chk("irq_dropped", {31'b0, irq}, 32'd0);
    cpu_rd("rx_empty_read", 8'h04, 16'h0000);
    cpu_rd("unf_status", 8'h05, 16'h00A5);
    cpu_wr(8'h05, 16'h0020);
    cpu_rd("unf_cleared", 8'h05, 16'h0005);

    // Full RX on ch2 with simultaneous device push and CPU pop
    for (int k = 0; k < 8; k++) dev_push(2, 16'h2000 + 16'(k));
    chk("rx_ready_full", {28'b0, rx_ready}, 32'h0000_000B);
    cpu_rd("rx_full_status", 8'h05, 16'h0806);
    rx_valid[2] = 1'b1;
    rx_data[32 +: 16] = 16'h2FFF;
    cpu_rd("rx_full_pop", 8'h04, 16'h2000);
    rx_valid[2] = 1'b0;
    cpu_rd("rx_after_full_pop", 8'h05, 16'h0704);
    dev_push(2, 16'h2100);
    cpu_rd("rx_refull", 8'h05, 16'h0806);
    cpu_rd("rx_2001", 8'h04, 16'h2001);
    rx_valid[2] = 1'b1;
    rx_data[32 +: 16] = 16'h2200;
    cpu_rd("rx_push_pop_2002", 8'h04, 16'h2002);
    rx_valid[2] = 1'b0;
    cpu_rd("rx_cnt_unchanged", 8'h05, 16'h0704);
    for (int k = 3; k < 8; k++)
      cpu_rd("rx_drain", 8'h04, 16'h2000 + 16'(k));
    cpu_rd("rx_drain_2100", 8'h04, 16'h2100);
    cpu_rd("rx_drain_2200", 8'h04, 16'h2200);

    // Empty read with simultaneous device push on ch3
    rx_valid[3] = 1'b1;
    rx_data[48 +: 16] = 16'h3333;
    cpu_rd("empty_read_push", 8'h06, 16'h0000);
    rx_valid[3] = 1'b0;
    cpu_rd("empty_push_status", 8'h07, 16'h0124);
    cpu_rd("empty_push_kept", 8'h06, 16'h3333);

    // Full TX on ch0: CPU write and device pop together
    for (int k = 0; k < 8; k++) begin
      cpu_wr(8'h00, 16'h0A00 + 16'(k));
      tx_q.push_back({4'd0, 16'h0A00 + 16'(k)});
    end
    tx_ready[0] = 1'b1;
    cpu_wr(8'h00, 16'h0AFF);
    tx_ready[0] = 1'b0;
    cpu_rd("tx_full_drop_status", 8'h01, 16'h0011);
    tx_ready[0] = 1'b1;
    repeat (9) cyc();
    tx_ready[0] = 1'b0;
    chk("tx_0aff_absent", {31'b0, tx_valid[0]}, 32'd0);
    chk("tx_q_consumed2", tx_q.size(), 32'd0);
    cpu_wr(8'h01, 16'h0010);

    // Loopback on ch1
    cpu_wr(8'h03, 16'h0040);
    rx_valid[1] = 1'b1;
    rx_data[16 +: 16] = 16'hDEAD;
    cpu_wr(8'h02, 16'h1234);
    chk("lb_tx_valid_low", {31'b0, tx_valid[1]}, 32'd0);
    chk("lb_rx_ready_low", {31'b0, rx_ready[1]}, 32'd0);
    cpu_rd("lb_in_tx", 8'h03, 16'h0041);
    cpu_rd("lb_data", 8'h02, 16'h1234);
    cpu_rd("lb_empty", 8'h03, 16'h0045);
    rx_valid[1] = 1'b0;
    cpu_wr(8'h03, 16'h0000);

    // Decode
    cpu_rd("unmapped_read", 8'h08, 16'h0000);
    cpu_wr(8'h08, 16'hFFFF);
    cpu_rd("unmapped_write_ign", 8'h01, 16'h0005);
    dev_push(2, 16'h4444);
    rd_q.push_back(16'h0000);
    tag_q.push_back("oe_we_both");
    tx_q.push_back({4'd2, 16'h5555});
    io_oe = 1'b1;
    cpu_wr(8'h04, 16'h5555);
    io_oe = 1'b0;
    cpu_rd("oe_we_no_pop", 8'h05, 16'h0100);
    tx_ready[2] = 1'b1;
    cyc();
    tx_ready[2] = 1'b0;
    cpu_rd("oe_we_rx_kept", 8'h04, 16'h4444);

    // Reset mid-traffic
    cpu_wr(8'h00, 16'h7777);
    cpu_wr(8'h00, 16'h7778);
    dev_push(3, 16'h8888);
    cpu_wr(8'h07, 16'h0080);
    chk("irq_before_rst", {31'b0, irq}, 32'd1);
    rst = 1'b0;
    #1;
    chk("rst_irq", {31'b0, irq}, 32'd0);
    chk("rst_tx_valid", {28'b0, tx_valid}, 32'd0);
    chk("rst_rx_ready", {28'b0, rx_ready}, 32'h0000_000F);
    cpu_rd("rst_io_out", 8'h07, 16'h0000);
    cyc();
    rst = 1'b1;
    cyc();
    for (int c = 0; c < 4; c++)
      cpu_rd("post_rst_status", 8'(2*c+1), 16'h0005);
    chk("post_rst_irq", {31'b0, irq}, 32'd0);

    repeat (2) cyc();
    chk("rd_q_consumed", rd_q.size(), 32'd0);
    chk("tx_q_final", tx_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
